// File: rtl/dct_coef_sequencer.sv
// dct_coef_sequencer: walks the (k1,k2,n1,n2) index space of one 2-D DCT pass, one term per MAC handshake.
//   clk, reset (sync, active-high), start -> request a pass (sampled in IDLE only)
//   busy/done -> pass in progress / one-cycle completion pulse
//   k1,k2,n1,n2, coef_idx={k1,k2} -> tuple for cos-LUT and MAC, qualified by term_valid/term_ready
//   acc_first/acc_last -> first/last term of a coefficient
//   Optional `define DCT_SEQ_ABORT_EN adds input abort, which cancels a running pass.
module dct_coef_sequencer #(
    parameter int N_LOG2 = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
`ifdef DCT_SEQ_ABORT_EN
    input  logic                abort,
`endif
    output logic                busy,
    output logic                done,
    output logic [N_LOG2-1:0]   k1,
    output logic [N_LOG2-1:0]   k2,
    output logic [N_LOG2-1:0]   n1,
    output logic [N_LOG2-1:0]   n2,
    output logic                term_valid,
    input  logic                term_ready,
    output logic                acc_first,
    output logic                acc_last,
    output logic [2*N_LOG2-1:0] coef_idx
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    // One counter holds the whole tuple: n2 in the LSBs gives the required nesting and carries for free.
    logic [4*N_LOG2-1:0] cnt_q, cnt_d;
    logic hs, abort_w;
`ifdef DCT_SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif
    assign {k1, k2, n1, n2} = cnt_q;
    assign coef_idx   = {k1, k2};
    assign term_valid = state_q == RUN;
    assign busy       = state_q != IDLE;
    assign done       = state_q == DONE;
    assign hs         = term_valid && term_ready;
    assign acc_first  = term_valid && ({n1, n2} == '0);
    assign acc_last   = term_valid && (&{n1, n2});
    always_comb begin
        state_d = (state_q == IDLE) ? (start ? RUN : IDLE) :
                  (state_q == RUN)  ? (abort_w ? IDLE : (hs && (&cnt_q)) ? DONE : RUN) :
                  IDLE;
        // The final handshake wraps the counter to zero, so IDLE always holds zero indices.
        cnt_d = (term_valid && abort_w) ? '0 : hs ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_dct_coef_sequencer.sv
// tb_dct_coef_sequencer: randomized self-checking bench for dct_coef_sequencer at N_LOG2=3.
module tb_dct_coef_sequencer;
    localparam int TERMS = 4096;
    logic clk = 1'b0;
    logic reset, start, term_ready, busy, done, term_valid, acc_first, acc_last;
    logic [2:0] k1, k2, n1, n2;
    logic [5:0] coef_idx;
`ifdef DCT_SEQ_ABORT_EN
    logic abort = 1'b0;
`endif
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dct_coef_sequencer #(.N_LOG2(3)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
`ifdef DCT_SEQ_ABORT_EN
        .abort(abort),
`endif
        .busy(busy),
        .done(done),
        .k1(k1),
        .k2(k2),
        .n1(n1),
        .n2(n2),
        .term_valid(term_valid),
        .term_ready(term_ready),
        .acc_first(acc_first),
        .acc_last(acc_last),
        .coef_idx(coef_idx)
    );

    // Tuple of the h-th term of a pass: n2 fastest, k1 slowest; packed as {k1,k2,n1,n2,coef_idx}.
    function automatic logic [17:0] exp_tup(input int h);
        int k1e, k2e, n1e, n2e;
        k1e = h / 512;
        k2e = (h / 64) % 8;
        n1e = (h / 8) % 8;
        n2e = h % 8;
        return {3'(k1e), 3'(k2e), 3'(n1e), 3'(n2e), 3'(k1e), 3'(k2e)};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        term_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, term_valid, acc_first, acc_last, k1, k2, n1, n2, coef_idx} !== 23'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", {busy, done, term_valid, acc_first, acc_last, k1, k2, n1, n2, coef_idx});
        end
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, term_valid, acc_first, acc_last, k1, k2, n1, n2, coef_idx} !== 23'd0) begin
            failures++;
            $display("FAIL idle_after_reset got=%h want=0", {busy, done, term_valid, acc_first, acc_last, k1, k2, n1, n2, coef_idx});
        end
    endtask

    // mode: 0 ready always 1, 1 ready pattern 1,0,0,1, 2 random ready.
    // start_at: extra start pulse once the model reaches that handshake count (-1 none).
    // cut_at: reset (or abort when cut_abort) once that handshake count is reached (-1 none).
    task automatic run_pass(input string name, input int mode, input int start_at, input int cut_at, input bit cut_abort);
        int h = 0, nf = 0, nl = 0, nd = 0, dc = -1, c = 0, idle_left = 0, ph = 1, shown = 0;
        bit r, sa = 1'b0, cut = 1'b0;
        logic [4:0] ectl;
        logic [17:0] etup;
        start = 1'b1;
        term_ready = 1'b1;
        while (!(ph == 3 && idle_left == 0) && c < 20000) begin
            @(negedge clk);
            c++;
            start = 1'b0;
            reset = 1'b0;
`ifdef DCT_SEQ_ABORT_EN
            abort = 1'b0;
`endif
            ectl = (ph == 1) ? {3'b101, 1'(h % 64 == 0), 1'(h % 64 == 63)} : (ph == 2) ? 5'b11000 : 5'b00000;
            checks++;
            if ({busy, done, term_valid, acc_first, acc_last} !== ectl) begin
                failures++;
                if (shown++ < 20) $display("FAIL %s ctl cyc=%0d h=%0d got=%b want=%b", name, c, h, {busy, done, term_valid, acc_first, acc_last}, ectl);
            end
            if (ph != 2) begin
                etup = exp_tup(ph == 1 ? h : 0);
                checks++;
                if ({k1, k2, n1, n2, coef_idx} !== etup) begin
                    failures++;
                    if (shown++ < 20) $display("FAIL %s tuple cyc=%0d h=%0d got=%h want=%h", name, c, h, {k1, k2, n1, n2, coef_idx}, etup);
                end
            end
            if (done) begin
                nd++;
                dc = c;
            end
            if (ph == 1) begin
                if (cut_at >= 0 && h == cut_at) begin
                    if (cut_abort) begin
`ifdef DCT_SEQ_ABORT_EN
                        abort = 1'b1;
`endif
                    end else begin
                        reset = 1'b1;
                        start = 1'b1;
                    end
                    term_ready = 1'b1;
                    cut = 1'b1;
                    ph = 3;
                    idle_left = 4;
                end else begin
                    r = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 4 == 0 || c % 4 == 3) : ($urandom_range(0, 3) != 0);
                    term_ready = r;
                    if (h == start_at && !sa) begin
                        start = 1'b1;
                        sa = 1'b1;
                    end
                    if (r) begin
                        if (acc_first) nf++;
                        if (acc_last) begin
                            checks++;
                            if (coef_idx !== 6'(nl)) begin
                                failures++;
                                $display("FAIL %s last_order got=%0d want=%0d", name, coef_idx, nl);
                            end
                            nl++;
                        end
                        h++;
                        if (h == TERMS) ph = 2;
                    end
                end
            end else if (ph == 2) begin
                ph = 3;
                idle_left = 2;
            end
            if (ph == 3 && idle_left > 0) idle_left--;
        end
        checks++;
        if (c >= 20000) begin
            failures++;
            $display("FAIL %s timeout got=%0d cycles want<20000", name, c);
        end
        checks++;
        if (nd !== (cut ? 0 : 1)) begin
            failures++;
            $display("FAIL %s done_count got=%0d want=%0d", name, nd, cut ? 0 : 1);
        end
        if (!cut) begin
            checks++;
            if (h !== TERMS || nf !== 64 || nl !== 64) begin
                failures++;
                $display("FAIL %s counts got=%0d/%0d/%0d want=4096/64/64", name, h, nf, nl);
            end
            if (mode == 0) begin
                checks++;
                if (dc + 1 !== TERMS + 2) begin
                    failures++;
                    $display("FAIL %s done_latency got=%0d want=%0d", name, dc + 1, TERMS + 2);
                end
            end
        end
    endtask

    task automatic test_full_pass();
        run_pass("full_pass", 0, -1, -1, 1'b0);
    endtask

    task automatic test_stall();
        run_pass("stall", 1, -1, -1, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_pass("start_ignored", 2, 100, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_pass("reset_mid", 0, -1, 2000, 1'b0);
        run_pass("after_reset", 0, -1, -1, 1'b0);
    endtask

`ifdef DCT_SEQ_ABORT_EN
    task automatic test_abort();
        run_pass("abort", 2, -1, 500, 1'b1);
        run_pass("after_abort", 0, -1, -1, 1'b0);
    endtask
`endif

    initial begin
        reset = 1'b1;
        start = 1'b0;
        term_ready = 1'b0;
        test_reset();
        test_full_pass();
        test_stall();
        test_start_ignored();
        test_reset_mid();
`ifdef DCT_SEQ_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
